// File: rtl/floor_track_reg_pkg.sv
// Shared definitions for the floor tracking register and its neighbours
// (request scheduler, floor display). Holds the FSM state encoding, the
// direction codes and the default floor geometry.
package floor_track_reg_pkg;

   // Default geometry, shared with the scheduler and display logic
   localparam int unsigned FLOOR_W_DEF       = 4;
   localparam int unsigned NUM_FLOORS_DEF    = 16;
   localparam int unsigned TRAVEL_CYCLES_DEF = 8;

   // Tracker FSM states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVING = 2'd1,
      ARRIVE = 2'd2
   } state_e;

   // Direction codes; bit 0 drives dir_up, bit 1 drives dir_dn
   typedef enum logic [1:0] {
      DIR_NONE = 2'b00,
      DIR_UP   = 2'b01,
      DIR_DN   = 2'b10
   } dir_e;

endpackage

// File: rtl/floor_track_reg_travel_timer.sv
// Travel timer: TMR_W-bit down-counter paced by en_i, used to space the
// one-floor steps of the tracker.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : force count to zero (highest priority)
//   reload_i   : load RELOAD into the counter
//   en_i       : count down by one while nonzero
//   zero_o     : count is zero
module floor_track_reg_travel_timer #(
   parameter int unsigned TMR_W  = 4,
   parameter int unsigned RELOAD = 7
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic reload_i,
   input  logic en_i,
   output logic zero_o
);

   logic [TMR_W-1:0] cnt_q;
   logic [TMR_W-1:0] cnt_d;

   // Next count: clear > reload > decrement; holds at zero
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (reload_i) begin
         cnt_d = TMR_W'(RELOAD);
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - TMR_W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/floor_track_reg.sv
// Floor tracking register: holds the current floor, accepts a target floor
// through a valid/ready handshake and steps toward it one floor every
// TRAVEL_CYCLES clocks, pulsing arrived on reaching it. A calibration load
// path overrides everything except reset.
//   clk, reset          : clock, async active-low reset
//   load, load_val      : force floor to min(load_val, NUM_FLOORS-1)
//   req_valid/req_floor : target request; req_ready is combinational
//   hold                : freezes travel while high
//   floor               : current floor
//   dir_up, dir_dn      : direction of travel
//   busy                : travelling
//   arrived, err        : one-cycle pulses (arrival / out-of-range request)
module floor_track_reg
   import floor_track_reg_pkg::*;
#(
   parameter int unsigned FLOOR_W       = FLOOR_W_DEF,
   parameter int unsigned NUM_FLOORS    = NUM_FLOORS_DEF,
   parameter int unsigned TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
   parameter int unsigned TMR_W         = $clog2(TRAVEL_CYCLES) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [FLOOR_W-1:0] load_val,
   input  logic               req_valid,
   input  logic [FLOOR_W-1:0] req_floor,
   output logic               req_ready,
   input  logic               hold,
   output logic [FLOOR_W-1:0] floor,
   output logic               dir_up,
   output logic               dir_dn,
   output logic               busy,
   output logic               arrived,
   output logic               err
);

   // One extra bit so range checks stay meaningful when NUM_FLOORS == 2**FLOOR_W
   localparam int unsigned EXT_W = FLOOR_W + 1;

   state_e             state_q, state_d;
   dir_e               dir_q, dir_d;
   logic [FLOOR_W-1:0] floor_q, floor_d;
   logic [FLOOR_W-1:0] target_q, target_d;
   logic               busy_q, busy_d;
   logic               arrived_q, arrived_d;
   logic               err_q, err_d;

   logic               accept;
   logic               req_oor;
   logic [FLOOR_W-1:0] load_sat;
   logic [FLOOR_W-1:0] floor_step;
   logic               tmr_clr;
   logic               tmr_reload;
   logic               tmr_en;
   logic               tmr_zero;

   assign req_ready  = (state_q == IDLE) & ~load;
   assign accept     = req_valid & req_ready;
   assign req_oor    = ({1'b0, req_floor} >= EXT_W'(NUM_FLOORS));
   assign load_sat   = ({1'b0, load_val} > EXT_W'(NUM_FLOORS - 1)) ?
                       FLOOR_W'(NUM_FLOORS - 1) : load_val;
   assign floor_step = (dir_q == DIR_UP) ? floor_q + FLOOR_W'(1)
                                         : floor_q - FLOOR_W'(1);
   assign tmr_en     = (state_q == MOVING) & ~hold;

   floor_track_reg_travel_timer #(
      .TMR_W  (TMR_W),
      .RELOAD (TRAVEL_CYCLES - 1)
   ) u_timer (
      .clk      (clk),
      .rst_n    (reset),
      .clr_i    (tmr_clr),
      .reload_i (tmr_reload),
      .en_i     (tmr_en),
      .zero_o   (tmr_zero)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         dir_q     <= DIR_NONE;
         floor_q   <= '0;
         target_q  <= '0;
         busy_q    <= 1'b0;
         arrived_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         floor_q   <= floor_d;
         target_q  <= target_d;
         busy_q    <= busy_d;
         arrived_q <= arrived_d;
         err_q     <= err_d;
      end
   end

   // Next-state, floor, target, direction and timer control
   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      floor_d    = floor_q;
      target_d   = target_q;
      tmr_clr    = 1'b0;
      tmr_reload = 1'b0;
      if (load) begin
         // Calibration aborts any motion without an arrival
         state_d = IDLE;
         floor_d = load_sat;
         dir_d   = DIR_NONE;
         tmr_clr = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept && !req_oor) begin
                  if (req_floor == floor_q) begin
                     state_d = ARRIVE;
                  end else begin
                     target_d   = req_floor;
                     dir_d      = (req_floor > floor_q) ? DIR_UP : DIR_DN;
                     tmr_reload = 1'b1;
                     state_d    = MOVING;
                  end
               end
            end
            MOVING: begin
               if (!hold && tmr_zero) begin
                  floor_d = floor_step;
                  if (floor_step == target_q) begin
                     state_d = ARRIVE;
                     dir_d   = DIR_NONE;
                  end else begin
                     tmr_reload = 1'b1;
                  end
               end
            end
            ARRIVE:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Registered status outputs follow the next state
   always_comb begin
      busy_d    = (state_d == MOVING);
      arrived_d = (state_d == ARRIVE);
      err_d     = accept & req_oor;
   end

   assign floor   = floor_q;
   assign dir_up  = dir_q[0];
   assign dir_dn  = dir_q[1];
   assign busy    = busy_q;
   assign arrived = arrived_q;
   assign err     = err_q;

endmodule

// File: tb/tb_floor_track_reg.sv
// Self-checking bench for floor_track_reg: a default instance (4-bit floors,
// 8 clocks per step) and a 5-bit instance with one step per clock.
module tb_floor_track_reg;

   logic       clk;
   logic       reset;
   // Default instance
   logic       load, req_valid, hold;
   logic [3:0] load_val, req_floor;
   logic       req_ready, dir_up, dir_dn, busy, arrived, err;
   logic [3:0] floor;
   // Wide-floor, single-cycle-travel instance
   logic       b_load, b_req_valid, b_hold;
   logic [4:0] b_load_val, b_req_floor;
   logic       b_req_ready, b_dir_up, b_dir_dn, b_busy, b_arrived, b_err;
   logic [4:0] b_floor;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic       load;
      logic [3:0] load_val;
      logic       req_valid;
      logic [3:0] req_floor;
      logic       exp_ready;
      logic [3:0] exp_floor;
      logic       exp_busy;
      logic       exp_arrived;
   } vec_t;

   vec_t vecs [6];

   floor_track_reg u_dut (
      .clk(clk), .reset(reset), .load(load), .load_val(load_val),
      .req_valid(req_valid), .req_floor(req_floor), .req_ready(req_ready),
      .hold(hold), .floor(floor), .dir_up(dir_up), .dir_dn(dir_dn),
      .busy(busy), .arrived(arrived), .err(err)
   );

   floor_track_reg #(.FLOOR_W(5), .NUM_FLOORS(16), .TRAVEL_CYCLES(1)) u_dut_b (
      .clk(clk), .reset(reset), .load(b_load), .load_val(b_load_val),
      .req_valid(b_req_valid), .req_floor(b_req_floor), .req_ready(b_req_ready),
      .hold(b_hold), .floor(b_floor), .dir_up(b_dir_up), .dir_dn(b_dir_dn),
      .busy(b_busy), .arrived(b_arrived), .err(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // One stationary cycle on the default instance: drive, check ready, clock, check
   task automatic apply_vec(input string nm, input vec_t v);
      load = v.load; load_val = v.load_val;
      req_valid = v.req_valid; req_floor = v.req_floor;
      #1;
      chk({nm, ".ready"}, 32'(req_ready), 32'(v.exp_ready));
      tick();
      chk({nm, ".floor"}, 32'(floor), 32'(v.exp_floor));
      chk({nm, ".busy"}, 32'(busy), 32'(v.exp_busy));
      chk({nm, ".arrived"}, 32'(arrived), 32'(v.exp_arrived));
      chk({nm, ".err"}, 32'(err), 32'd0);
      chk({nm, ".dir"}, 32'({dir_up, dir_dn}), 32'd0);
      load = 1'b0; req_valid = 1'b0;
   endtask

   // Request tgt from start, optional hold over cycles h_lo..h_hi, check every cycle
   task automatic move_seq(input string nm, input int start, input int tgt,
                           input int h_lo, input int h_hi);
      int  d, h, ce, lim, ef;
      bit  up;
      up  = (tgt > start);
      d   = up ? tgt - start : start - tgt;
      h   = 0;
      lim = d * 8 + 2 + ((h_hi >= h_lo) ? (h_hi - h_lo + 1) : 0);
      req_valid = 1'b1; req_floor = 4'(tgt);
      #1;
      chk({nm, ".ready0"}, 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      for (int c = 1; c <= lim; c++) begin
         ce = c - h;
         ef = up ? start + imin((ce - 1) / 8, d) : start - imin((ce - 1) / 8, d);
         chk({nm, ".floor"}, 32'(floor), 32'(ef));
         chk({nm, ".busy"}, 32'(busy), 32'(ce <= d * 8));
         chk({nm, ".arrived"}, 32'(arrived), 32'(ce == d * 8 + 1));
         chk({nm, ".dir_up"}, 32'(dir_up), 32'(up && ce <= d * 8));
         chk({nm, ".dir_dn"}, 32'(dir_dn), 32'(!up && ce <= d * 8));
         chk({nm, ".err"}, 32'(err), 32'd0);
         if (c == lim) chk({nm, ".ready_end"}, 32'(req_ready), 32'd1);
         hold = (c >= h_lo && c <= h_hi);
         if (hold) h++;
         tick();
         hold = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b0;
      load = 1'b0; load_val = '0; req_valid = 1'b0; req_floor = '0; hold = 1'b0;
      b_load = 1'b0; b_load_val = '0; b_req_valid = 1'b0; b_req_floor = '0; b_hold = 1'b0;

      vecs[0] = '{1'b1, 4'd5,  1'b0, 4'd0,  1'b0, 4'd5,  1'b0, 1'b0};
      vecs[1] = '{1'b1, 4'd15, 1'b0, 4'd0,  1'b0, 4'd15, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 4'd15, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 4'd0,  1'b1, 4'd15, 1'b1, 4'd15, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 4'd15, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 4'd5,  1'b0, 4'd0,  1'b0, 4'd5,  1'b0, 1'b0};

      // Reset held with random traffic (load kept low)
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'($urandom_range(0, 1));
         req_floor = 4'($urandom_range(0, 15));
         hold      = 1'($urandom_range(0, 1));
         load_val  = 4'($urandom_range(0, 15));
         tick();
         chk("rst.floor", 32'(floor), 32'd0);
         chk("rst.busy", 32'(busy), 32'd0);
         chk("rst.arrived", 32'(arrived), 32'd0);
         chk("rst.err", 32'(err), 32'd0);
         chk("rst.dir", 32'({dir_up, dir_dn}), 32'd0);
         chk("rst.ready", 32'(req_ready), 32'd1);
      end
      req_valid = 1'b0; req_floor = '0; hold = 1'b0; load_val = '0;
      reset = 1'b1;
      tick();

      move_seq("up3", 0, 3, 1, 0);

      foreach (vecs[i]) apply_vec($sformatf("vec%0d", i), vecs[i]);

      move_seq("dn2", 5, 2, 1, 0);
      move_seq("same2", 2, 2, 1, 0);

      apply_vec("load0", '{1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0});
      move_seq("hold", 0, 1, 3, 7);

      // Load mid-move aborts travel with no arrival
      apply_vec("load0b", '{1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0});
      req_valid = 1'b1; req_floor = 4'd6;
      tick();
      req_valid = 1'b0;
      for (int c = 1; c < 12; c++) tick();
      chk("ldmv.floor12", 32'(floor), 32'd1);
      chk("ldmv.busy12", 32'(busy), 32'd1);
      load = 1'b1; load_val = 4'd9;
      tick();
      load = 1'b0;
      chk("ldmv.floor13", 32'(floor), 32'd9);
      chk("ldmv.busy13", 32'(busy), 32'd0);
      chk("ldmv.arr13", 32'(arrived), 32'd0);
      chk("ldmv.dir13", 32'({dir_up, dir_dn}), 32'd0);
      tick();
      chk("ldmv.arr14", 32'(arrived), 32'd0);
      chk("ldmv.floor14", 32'(floor), 32'd9);
      chk("ldmv.ready14", 32'(req_ready), 32'd1);

      // Reset mid-move at cycle 10
      req_valid = 1'b1; req_floor = 4'd5;
      tick();
      req_valid = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      chk("rstmv.floor10", 32'(floor), 32'd8);
      chk("rstmv.dir10", 32'(dir_dn), 32'd1);
      reset = 1'b0;
      #1;
      chk("rstmv.floor", 32'(floor), 32'd0);
      chk("rstmv.busy", 32'(busy), 32'd0);
      chk("rstmv.dir", 32'({dir_up, dir_dn}), 32'd0);
      chk("rstmv.arrived", 32'(arrived), 32'd0);
      chk("rstmv.ready", 32'(req_ready), 32'd1);
      tick();
      reset = 1'b1;
      tick();
      chk("rstmv.floor_post", 32'(floor), 32'd0);
      chk("rstmv.arr_post", 32'(arrived), 32'd0);
      chk("rstmv.busy_post", 32'(busy), 32'd0);

      // Load and request together: request ignored
      apply_vec("ldreq", '{1'b1, 4'd4, 1'b1, 4'd7, 1'b0, 4'd4, 1'b0, 1'b0});
      apply_vec("ldreq2", '{1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd4, 1'b0, 1'b0});

      // Wide instance: out-of-range request raises err only
      b_req_valid = 1'b1; b_req_floor = 5'd16;
      #1;
      chk("b.oor.ready", 32'(b_req_ready), 32'd1);
      tick();
      b_req_valid = 1'b0;
      chk("b.oor.err", 32'(b_err), 32'd1);
      chk("b.oor.floor", 32'(b_floor), 32'd0);
      chk("b.oor.busy", 32'(b_busy), 32'd0);
      chk("b.oor.arrived", 32'(b_arrived), 32'd0);
      tick();
      chk("b.oor.err_end", 32'(b_err), 32'd0);
      chk("b.oor.ready_end", 32'(b_req_ready), 32'd1);

      // Wide instance: 15 is in range, one floor per clock
      b_req_valid = 1'b1; b_req_floor = 5'd15;
      tick();
      b_req_valid = 1'b0;
      for (int c = 1; c <= 17; c++) begin
         chk("b.up.floor", 32'(b_floor), 32'(imin(c - 1, 15)));
         chk("b.up.busy", 32'(b_busy), 32'(c <= 15));
         chk("b.up.arrived", 32'(b_arrived), 32'(c == 16));
         chk("b.up.dir_up", 32'(b_dir_up), 32'(c <= 15));
         chk("b.up.err", 32'(b_err), 32'd0);
         tick();
      end

      // Wide instance: load saturates at the top floor
      b_load = 1'b1; b_load_val = 5'd20;
      tick();
      chk("b.ld20", 32'(b_floor), 32'd15);
      b_load_val = 5'd14;
      tick();
      chk("b.ld14", 32'(b_floor), 32'd14);
      b_load_val = 5'd31;
      tick();
      b_load = 1'b0;
      chk("b.ld31", 32'(b_floor), 32'd15);
      b_req_valid = 1'b1; b_req_floor = 5'd31;
      tick();
      b_req_valid = 1'b0;
      chk("b.oor31.err", 32'(b_err), 32'd1);
      chk("b.oor31.floor", 32'(b_floor), 32'd15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
